// File: rtl/nco_pkg.sv
// rtl/nco_pkg.sv - shared NCO sweep types and defaults
package nco_pkg;

    localparam int NCO_PHI_W = 32;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        NCO_RST    = 2'd1,
        WAIT_VALID = 2'd2,
        DWELL      = 2'd3
    } sweep_state_t;

    typedef logic [NCO_PHI_W-1:0] phi_inc_t;

endpackage

// File: rtl/nco_sweep_phase_acc.sv
// rtl/nco_sweep_phase_acc.sv - phase-increment register with load/add/hold
module nco_sweep_phase_acc #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic         add,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] step,
    output logic [W-1:0] phi
);

    // Load wins over add; the add wraps modulo 2^W by design.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            phi <= '0;
        end else if (load) begin
            phi <= load_val;
        end else if (add) begin
            phi <= phi + step;
        end
    end

endmodule

// File: rtl/nco_sweep_ctrl.sv
// rtl/nco_sweep_ctrl.sv - linear frequency-sweep sequencer driving the NCO
module nco_sweep_ctrl
    import nco_pkg::*;
#(
    parameter int PHI_W          = NCO_PHI_W,
    parameter int STEP_W         = 16,
    parameter int DWELL_W        = 16,
    parameter int NCO_RST_CYCLES = 8,
    parameter int VALID_TIMEOUT  = 1024
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [PHI_W-1:0]   cfg_start_phi,
    input  logic [PHI_W-1:0]   cfg_step_phi,
    input  logic [STEP_W-1:0]  cfg_num_steps,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               cfg_continuous,
    input  logic               start,
    input  logic               abort,
    input  logic               nco_out_valid,
    output logic               nco_reset_n,
    output logic               nco_clken,
    output logic [PHI_W-1:0]   nco_phi_inc,
    output logic               busy,
    output logic               step_strobe,
    output logic [STEP_W-1:0]  step_idx,
    output logic               done,
    output logic               err
);

    localparam int RST_W = $clog2(NCO_RST_CYCLES + 1);
    localparam int TMO_W = $clog2(VALID_TIMEOUT + 1);

    sweep_state_t       state, state_nxt;
    logic [RST_W-1:0]   rst_cnt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [DWELL_W-1:0] dwell_cnt, dwell_lim;
    logic [STEP_W-1:0]  steps_lim;
    logic [PHI_W-1:0]   lat_start, lat_step, load_val;
    logic               lat_cont;
    logic               acc_load, acc_add;
    logic               rst_last, tmo_last, dwell_last, point_last;

    assign rst_last    = (rst_cnt == RST_W'(NCO_RST_CYCLES - 1));
    assign tmo_last    = (tmo_cnt == TMO_W'(VALID_TIMEOUT - 1));
    assign dwell_last  = (dwell_cnt == dwell_lim);
    assign point_last  = (step_idx == steps_lim);
    assign busy        = (state != IDLE);
    assign nco_reset_n = (state == WAIT_VALID) || (state == DWELL);
    assign nco_clken   = nco_reset_n;
    // A fresh start loads the live config; a continuous re-loop reloads the latched copy.
    assign load_val    = (state == IDLE) ? cfg_start_phi : lat_start;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_load  = 1'b0;
        acc_add   = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nxt = NCO_RST;
                    acc_load  = 1'b1;
                end
            end
            NCO_RST: begin
                if (abort)         state_nxt = IDLE;
                else if (rst_last) state_nxt = WAIT_VALID;
            end
            WAIT_VALID: begin
                if (abort)              state_nxt = IDLE;
                else if (nco_out_valid) state_nxt = DWELL;
                else if (tmo_last)      state_nxt = IDLE;
            end
            DWELL: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (dwell_last) begin
                    if (!point_last)   acc_add   = 1'b1;
                    else if (lat_cont) acc_load  = 1'b1;
                    else               state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rst_cnt     <= '0;
            tmo_cnt     <= '0;
            dwell_cnt   <= '0;
            dwell_lim   <= '0;
            steps_lim   <= '0;
            lat_start   <= '0;
            lat_step    <= '0;
            lat_cont    <= 1'b0;
            step_idx    <= '0;
            step_strobe <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            step_strobe <= 1'b0;
            done        <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        lat_start <= cfg_start_phi;
                        lat_step  <= cfg_step_phi;
                        steps_lim <= (cfg_num_steps == '0) ? '0 : cfg_num_steps - STEP_W'(1);
                        dwell_lim <= (cfg_dwell == '0) ? '0 : cfg_dwell - DWELL_W'(1);
                        lat_cont  <= cfg_continuous;
                        step_idx  <= '0;
                        err       <= 1'b0;
                        rst_cnt   <= '0;
                    end
                end
                NCO_RST: begin
                    rst_cnt <= rst_cnt + RST_W'(1);
                    tmo_cnt <= '0;
                end
                WAIT_VALID: begin
                    tmo_cnt   <= tmo_cnt + TMO_W'(1);
                    dwell_cnt <= '0;
                    if (!abort && nco_out_valid) step_strobe <= 1'b1;
                    else if (!abort && tmo_last) err         <= 1'b1;
                end
                DWELL: begin
                    if (!abort) begin
                        if (!dwell_last) begin
                            dwell_cnt <= dwell_cnt + DWELL_W'(1);
                        end else begin
                            dwell_cnt <= '0;
                            if (!point_last) begin
                                step_idx    <= step_idx + STEP_W'(1);
                                step_strobe <= 1'b1;
                            end else begin
                                done <= 1'b1;
                                if (lat_cont) begin
                                    step_idx    <= '0;
                                    step_strobe <= 1'b1;
                                end
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    nco_sweep_phase_acc #(
        .W(PHI_W)
    ) u_phase_acc (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (acc_load),
        .add      (acc_add),
        .load_val (load_val),
        .step     (lat_step),
        .phi      (nco_phi_inc)
    );

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// tb/tb_nco_sweep_ctrl.sv - self-checking bench for nco_sweep_ctrl
module tb_nco_sweep_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] cfg_start_phi;
    logic [31:0] cfg_step_phi;
    logic [15:0] cfg_num_steps;
    logic [15:0] cfg_dwell;
    logic        cfg_continuous;
    logic        start;
    logic        abort;
    logic        nco_out_valid;
    logic        nco_reset_n;
    logic        nco_clken;
    logic [31:0] nco_phi_inc;
    logic        busy;
    logic        step_strobe;
    logic [15:0] step_idx;
    logic        done;
    logic        err;

    nco_sweep_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cfg_start_phi  (cfg_start_phi),
        .cfg_step_phi   (cfg_step_phi),
        .cfg_num_steps  (cfg_num_steps),
        .cfg_dwell      (cfg_dwell),
        .cfg_continuous (cfg_continuous),
        .start          (start),
        .abort          (abort),
        .nco_out_valid  (nco_out_valid),
        .nco_reset_n    (nco_reset_n),
        .nco_clken      (nco_clken),
        .nco_phi_inc    (nco_phi_inc),
        .busy           (busy),
        .step_strobe    (step_strobe),
        .step_idx       (step_idx),
        .done           (done),
        .err            (err)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   errors   = 0;
    int   rel_cnt  = 0;
    int   vdelay   = 3;
    logic valid_en = 1'b1;

    typedef struct {
        logic [31:0] start_phi;
        logic [31:0] step_phi;
        logic [15:0] num;
        logic [15:0] dwell;
        int          disturb;
        logic [31:0] exp_last;
        int          exp_points;
        int          exp_cycles;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the edge, and the NCO
    // model raises out_valid vdelay cycles after its reset is released.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!nco_reset_n) begin
            rel_cnt       = 0;
            nco_out_valid = 1'b0;
        end else begin
            rel_cnt++;
            nco_out_valid = valid_en && (rel_cnt >= vdelay);
        end
    endtask

    task automatic run_oneshot(input vec_t v, input int id);
        int          points = 0;
        int          dcyc = 0;
        int          rst_low = 0;
        int          last_s = 0;
        logic        seen = 1'b0;
        logic [31:0] exp_phi;
        logic [15:0] dwell_eff;
        dwell_eff      = (v.dwell == 16'd0) ? 16'd1 : v.dwell;
        exp_phi        = v.start_phi;
        cfg_start_phi  = v.start_phi;
        cfg_step_phi   = v.step_phi;
        cfg_num_steps  = v.num;
        cfg_dwell      = v.dwell;
        cfg_continuous = 1'b0;
        start          = 1'b1;
        tick();
        start = 1'b0;
        check($sformatf("v%0d_busy_after_start", id), busy, 1);
        check($sformatf("v%0d_phi_loaded", id), nco_phi_inc, v.start_phi);
        for (int cyc = 0; cyc < 3000 && busy; cyc++) begin
            if (!nco_reset_n) rst_low++;
            if (step_strobe) begin
                check($sformatf("v%0d_phi_pt%0d", id, points), nco_phi_inc, exp_phi);
                check($sformatf("v%0d_idx_pt%0d", id, points), step_idx, points);
                check($sformatf("v%0d_clken_pt%0d", id, points), nco_clken, 1);
                if (seen) check($sformatf("v%0d_spacing_pt%0d", id, points), cyc - last_s, dwell_eff);
                seen    = 1'b1;
                last_s  = cyc;
                exp_phi = exp_phi + v.step_phi;
                points++;
            end
            if (seen) dcyc++;
            start = (cyc == v.disturb);
            if (start) begin
                cfg_start_phi  = 32'h5555AAAA;
                cfg_num_steps  = 16'd7;
                cfg_dwell      = 16'd9;
                cfg_continuous = 1'b1;
            end
            tick();
        end
        start = 1'b0;
        check($sformatf("v%0d_finished", id), busy, 0);
        check($sformatf("v%0d_done", id), done, 1);
        check($sformatf("v%0d_points", id), points, v.exp_points);
        check($sformatf("v%0d_dwell_cycles", id), dcyc, v.exp_cycles);
        check($sformatf("v%0d_nco_rst_cycles", id), rst_low, 8);
        check($sformatf("v%0d_final_phi", id), nco_phi_inc, v.exp_last);
        tick();
        check($sformatf("v%0d_done_single", id), done, 0);
    endtask

    initial begin
        logic [31:0] cphi[3];
        int          n;

        vecs[0] = '{32'h19A02752, 32'h00100000, 16'd4, 16'd5, -1, 32'h19D02752, 4, 20};
        vecs[1] = '{32'h00080000, 32'hFFF00000, 16'd2, 16'd1, -1, 32'hFFF80000, 2, 2};
        vecs[2] = '{32'hDEADBEEF, 32'h00000001, 16'd0, 16'd0, -1, 32'hDEADBEEF, 1, 1};
        vecs[3] = '{32'hFFFFFFF0, 32'h00000010, 16'd3, 16'd2, 14, 32'h00000010, 3, 6};
        vecs[4] = '{32'h12345678, 32'h00000000, 16'd1, 16'd3, 4, 32'h12345678, 1, 3};

        reset_n        = 1'b0;
        cfg_start_phi  = '0;
        cfg_step_phi   = '0;
        cfg_num_steps  = '0;
        cfg_dwell      = '0;
        cfg_continuous = 1'b0;
        start          = 1'b0;
        abort          = 1'b0;
        nco_out_valid  = 1'b0;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_nco_reset_n", nco_reset_n, 0);
        check("rst_clken", nco_clken, 0);
        check("rst_phi", nco_phi_inc, 0);
        check("rst_strobe", step_strobe, 0);
        check("rst_idx", step_idx, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        reset_n = 1'b1;
        tick();
        check("idle_after_release", busy, 0);

        for (int i = 0; i < 5; i++) run_oneshot(vecs[i], i);

        start = 1'b1;
        abort = 1'b1;
        cfg_start_phi = 32'hCAFEF00D;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", busy, 0);
        check("start_abort_phi_hold", nco_phi_inc, 32'h12345678);

        // Continuous: 3 points x 2 cycles, abort 15 cycles into DWELL.
        cphi[0] = 32'h00001000;
        cphi[1] = 32'h00001100;
        cphi[2] = 32'h00001200;
        cfg_start_phi  = 32'h00001000;
        cfg_step_phi   = 32'h00000100;
        cfg_num_steps  = 16'd3;
        cfg_dwell      = 16'd2;
        cfg_continuous = 1'b1;
        start          = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 100 && !step_strobe; i++) tick();
        check("cont_first_strobe", step_strobe, 1);
        for (int d = 0; d < 15; d++) begin
            check($sformatf("cont_phi_d%0d", d), nco_phi_inc, cphi[(d % 6) / 2]);
            check($sformatf("cont_done_d%0d", d), done, (d == 6 || d == 12));
            check($sformatf("cont_strobe_d%0d", d), step_strobe, (d % 2 == 0));
            check($sformatf("cont_nco_rst_d%0d", d), nco_reset_n, 1);
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_no_done", done, 0);
        check("abort_err", err, 0);
        tick();
        check("abort_no_done_later", done, 0);

        // Valid timeout.
        valid_en       = 1'b0;
        cfg_continuous = 1'b0;
        start          = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        for (int i = 0; i < 2000 && busy; i++) begin
            n++;
            tick();
        end
        check("tmo_busy_cycles", n, 1032);
        check("tmo_err", err, 1);
        check("tmo_no_done", done, 0);
        valid_en = 1'b1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        check("restart_clears_err", err, 0);
        check("restart_busy", busy, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_rst_busy", busy, 0);

        // reset_n mid-sweep.
        cfg_start_phi = 32'h19A02752;
        cfg_step_phi  = 32'h00100000;
        cfg_num_steps = 16'd4;
        cfg_dwell     = 16'd5;
        start         = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        check("mid_in_dwell", nco_reset_n, 1);
        reset_n = 1'b0;
        tick();
        check("mid_rst_busy", busy, 0);
        check("mid_rst_phi", nco_phi_inc, 0);
        check("mid_rst_clken", nco_clken, 0);
        check("mid_rst_idx", step_idx, 0);
        check("mid_rst_strobe", step_strobe, 0);
        reset_n = 1'b1;
        tick();
        check("mid_rst_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
